// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and constants for the data memory arbiter.
package memory_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    // Requester identifiers; also used as bit positions in valid/grant vectors
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    // Width of the access wait counter (WAIT_CYCLES is 1..15)
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Request/response channel between one requester and the memory arbiter.
interface data_memory_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;

    // Requester side
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/data_memory_arbiter_picker.sv
// Combinational 2-way round-robin picker: a lone requester always wins,
// a tie goes to the requester named by the priority pointer.
module rr_picker_2
    import memory_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       grant_id
);

    // Select the winner, then expand it into a one-hot grant
    always_comb begin
        grant_id = REQ_CPU;
        grant    = 2'b00;
        if (valid == 2'b11) begin
            grant_id = ptr;
        end else if (valid[REQ_DBG]) begin
            grant_id = REQ_DBG;
        end
        if (|valid) begin
            grant[grant_id] = 1'b1;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares a single-port data memory between the CPU port and a debug/loader
// port. One transaction at a time: IDLE (grant) -> ACCESS (WAIT_CYCLES) -> RESP.
module data_memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    data_memory_arbiter_if.slave cpu,
    data_memory_arbiter_if.slave dbg,
    output logic [ADDR_W-1:0]    mem_address,
    output logic [DATA_W-1:0]    mem_data_in,
    output logic                 mem_write_enable,
    input  logic [DATA_W-1:0]    mem_data_out
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);

    arb_state_t            state_reg, state_next;
    logic [WAIT_CNT_W-1:0] cnt_reg, cnt_next;
    logic                  ptr_reg, ptr_next;
    logic                  lat_id_reg, lat_id_next;
    logic                  lat_write_reg, lat_write_next;
    logic [ADDR_W-1:0]     lat_addr_reg, lat_addr_next;
    logic [DATA_W-1:0]     lat_wdata_reg, lat_wdata_next;

    logic [1:0]            pick_valid;
    logic [1:0]            grant;
    logic                  grant_id;
    logic                  last_access;
    logic [1:0]            resp_valid_vec;
    logic [DATA_W-1:0]     resp_rdata_vec [2];

    // Requests are only offered in IDLE and never while reset is held,
    // so ready is low during reset and throughout ACCESS/RESP.
    assign pick_valid = (state_reg == ARB_IDLE && reset) ?
                        {dbg.req_valid, cpu.req_valid} : 2'b00;

    rr_picker_2 u_picker (
        .valid    (pick_valid),
        .ptr      (ptr_reg),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign cpu.req_ready = grant[REQ_CPU];
    assign dbg.req_ready = grant[REQ_DBG];

    assign last_access      = (state_reg == ARB_ACCESS) && (cnt_reg == '0);
    assign mem_write_enable = last_access && lat_write_reg;
    // Address/data come from the latched request and simply hold in IDLE
    assign mem_address      = lat_addr_reg;
    assign mem_data_in      = lat_wdata_reg;

    // Per-requester read-data register and response pulse
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            logic [DATA_W-1:0] rdata_reg;

            // Capture read data on the last ACCESS cycle; stores return 0
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rdata_reg <= '0;
                end else if (last_access && lat_id_reg == 1'(gi)) begin
                    rdata_reg <= lat_write_reg ? '0 : mem_data_out;
                end
            end

            assign resp_rdata_vec[gi] = rdata_reg;
            assign resp_valid_vec[gi] = (state_reg == ARB_RESP) && (lat_id_reg == 1'(gi));
        end
    endgenerate

    assign cpu.resp_valid = resp_valid_vec[REQ_CPU];
    assign cpu.resp_rdata = resp_rdata_vec[REQ_CPU];
    assign dbg.resp_valid = resp_valid_vec[REQ_DBG];
    assign dbg.resp_rdata = resp_rdata_vec[REQ_DBG];

    // State, counter, pointer and latched request registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ARB_IDLE;
            cnt_reg       <= '0;
            ptr_reg       <= REQ_CPU;
            lat_id_reg    <= REQ_CPU;
            lat_write_reg <= 1'b0;
            lat_addr_reg  <= '0;
            lat_wdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            ptr_reg       <= ptr_next;
            lat_id_reg    <= lat_id_next;
            lat_write_reg <= lat_write_next;
            lat_addr_reg  <= lat_addr_next;
            lat_wdata_reg <= lat_wdata_next;
        end
    end

    // Next-state logic: latch the winner, count down the access, flip priority
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        ptr_next       = ptr_reg;
        lat_id_next    = lat_id_reg;
        lat_write_next = lat_write_reg;
        lat_addr_next  = lat_addr_reg;
        lat_wdata_next = lat_wdata_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (|grant) begin
                    lat_id_next    = grant_id;
                    lat_write_next = (grant_id == REQ_DBG) ? dbg.req_write : cpu.req_write;
                    lat_addr_next  = (grant_id == REQ_DBG) ? dbg.req_addr  : cpu.req_addr;
                    lat_wdata_next = (grant_id == REQ_DBG) ? dbg.req_wdata : cpu.req_wdata;
                    cnt_next       = WAIT_LOAD;
                    state_next     = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                if (cnt_reg == '0) begin
                    state_next = ARB_RESP;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ARB_RESP: begin
                ptr_next   = ~lat_id_reg;
                state_next = ARB_IDLE;
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: two instances (WAIT_CYCLES=1 and 3) with
// behavioural memories; expected grants/responses are queued by the stimulus
// and checked by a negedge monitor.
module tb_data_memory_arbiter;

    localparam int WAIT_B = 3;

    typedef struct {
        logic        id;
        logic [31:0] rdata;
    } resp_t;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    resp_t exp_resp_a [$];
    resp_t exp_resp_b [$];
    logic  exp_grant_a [$];
    logic  exp_grant_b [$];

    data_memory_arbiter_if cpu_a ();
    data_memory_arbiter_if dbg_a ();
    data_memory_arbiter_if cpu_b ();
    data_memory_arbiter_if dbg_b ();

    logic [31:0] mem_addr_a, mem_din_a, mem_rd_a;
    logic [31:0] mem_addr_b, mem_din_b, mem_rd_b;
    logic        we_a, we_b;
    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];

    data_memory_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) u_dut_a (
        .clk              (clk),
        .reset            (reset),
        .cpu              (cpu_a),
        .dbg              (dbg_a),
        .mem_address      (mem_addr_a),
        .mem_data_in      (mem_din_a),
        .mem_write_enable (we_a),
        .mem_data_out     (mem_rd_a)
    );

    data_memory_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(WAIT_B)) u_dut_b (
        .clk              (clk),
        .reset            (reset),
        .cpu              (cpu_b),
        .dbg              (dbg_b),
        .mem_address      (mem_addr_b),
        .mem_data_in      (mem_din_b),
        .mem_write_enable (we_b),
        .mem_data_out     (mem_rd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural word memories, combinational read
    assign mem_rd_a = mem_a[mem_addr_a[7:2]];
    assign mem_rd_b = mem_b[mem_addr_b[7:2]];
    always @(posedge clk) begin
        if (we_a) mem_a[mem_addr_a[7:2]] = mem_din_a;
        if (we_b) mem_b[mem_addr_b[7:2]] = mem_din_b;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected grants on handshakes and responses on resp_valid
    always @(negedge clk) begin
        if (reset) begin
            if (cpu_a.req_ready || dbg_a.req_ready) begin
                check("a_one_ready", {cpu_a.req_ready, dbg_a.req_ready}, (dbg_a.req_ready ? 2'b01 : 2'b10));
                if (exp_grant_a.size() == 0) check("a_grant_unexpected", 1, 0);
                else check("a_grant_id", dbg_a.req_ready, exp_grant_a.pop_front());
            end
            if (cpu_a.resp_valid || dbg_a.resp_valid) begin
                resp_t r;
                check("a_one_resp", cpu_a.resp_valid & dbg_a.resp_valid, 0);
                if (exp_resp_a.size() == 0) check("a_resp_unexpected", 1, 0);
                else begin
                    r = exp_resp_a.pop_front();
                    check("a_resp_id", dbg_a.resp_valid, r.id);
                    check("a_resp_rdata", dbg_a.resp_valid ? dbg_a.resp_rdata : cpu_a.resp_rdata, r.rdata);
                end
            end
            if (cpu_b.req_ready || dbg_b.req_ready) begin
                check("b_one_ready", {cpu_b.req_ready, dbg_b.req_ready}, (dbg_b.req_ready ? 2'b01 : 2'b10));
                if (exp_grant_b.size() == 0) check("b_grant_unexpected", 1, 0);
                else check("b_grant_id", dbg_b.req_ready, exp_grant_b.pop_front());
            end
            if (cpu_b.resp_valid || dbg_b.resp_valid) begin
                resp_t r;
                check("b_one_resp", cpu_b.resp_valid & dbg_b.resp_valid, 0);
                if (exp_resp_b.size() == 0) check("b_resp_unexpected", 1, 0);
                else begin
                    r = exp_resp_b.pop_front();
                    check("b_resp_id", dbg_b.resp_valid, r.id);
                    check("b_resp_rdata", dbg_b.resp_valid ? dbg_b.resp_rdata : cpu_b.resp_rdata, r.rdata);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs;
        int last;

        reset = 1'b0;
        cpu_a.req_valid = 0; cpu_a.req_write = 0; cpu_a.req_addr = 0; cpu_a.req_wdata = 0;
        dbg_a.req_valid = 0; dbg_a.req_write = 0; dbg_a.req_addr = 0; dbg_a.req_wdata = 0;
        cpu_b.req_valid = 0; cpu_b.req_write = 0; cpu_b.req_addr = 0; cpu_b.req_wdata = 0;
        dbg_b.req_valid = 0; dbg_b.req_write = 0; dbg_b.req_addr = 0; dbg_b.req_wdata = 0;
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        mem_a[2]  = 32'hDEADBEEF;
        mem_b[8]  = 32'hA0A00008;
        mem_b[9]  = 32'hB0B00009;
        mem_b[10] = 32'hC0C0000A;
        mem_b[11] = 32'hD0D0000B;
        mem_b[12] = 32'h11111111;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", {cpu_a.req_ready, dbg_a.req_ready, cpu_b.req_ready, dbg_b.req_ready}, 0);
        check("rst_resp_valid", {cpu_a.resp_valid, dbg_a.resp_valid, cpu_b.resp_valid, dbg_b.resp_valid}, 0);
        check("rst_rdata", {cpu_b.resp_rdata, dbg_b.resp_rdata}, 0);
        check("rst_mem_bus", {mem_addr_b, mem_din_b}, 0);
        check("rst_we", {we_a, we_b}, 0);
        @(posedge clk); #1 reset = 1'b1;
        step(); step();

        // Single CPU load on the WAIT_CYCLES=1 instance
        cpu_a.req_valid = 1; cpu_a.req_write = 0; cpu_a.req_addr = 32'h8;
        exp_grant_a.push_back(1'b0);
        exp_resp_a.push_back('{id: 1'b0, rdata: 32'hDEADBEEF});
        @(negedge clk);
        check("t1_ready_T", cpu_a.req_ready, 1);
        step();
        cpu_a.req_valid = 0;
        @(negedge clk);
        check("t1_addr_T1", mem_addr_a, 32'h8);
        repeat (3) step();

        // Debug store, WAIT_CYCLES=3
        dbg_b.req_valid = 1; dbg_b.req_write = 1; dbg_b.req_addr = 32'h10; dbg_b.req_wdata = 32'h12345678;
        exp_grant_b.push_back(1'b1);
        exp_resp_b.push_back('{id: 1'b1, rdata: 32'h0});
        @(negedge clk);
        check("t2_ready_T", {cpu_b.req_ready, dbg_b.req_ready}, 2'b01);
        step();
        dbg_b.req_valid = 0; dbg_b.req_write = 0;
        for (int k = 1; k <= WAIT_B + 1; k++) begin
            @(negedge clk);
            check("t2_we", we_b, (k == WAIT_B));
        end
        check("t2_mem_word4", mem_b[4], 32'h12345678);
        repeat (2) step();

        // Both valid continuously: CPU, DBG, CPU, DBG
        cpu_b.req_valid = 1; cpu_b.req_write = 0; cpu_b.req_addr = 32'h20;
        dbg_b.req_valid = 1; dbg_b.req_write = 0; dbg_b.req_addr = 32'h24;
        for (int k = 0; k < 2; k++) begin
            exp_grant_b.push_back(1'b0);
            exp_grant_b.push_back(1'b1);
            exp_resp_b.push_back('{id: 1'b0, rdata: 32'hA0A00008});
            exp_resp_b.push_back('{id: 1'b1, rdata: 32'hB0B00009});
        end
        hs = 0;
        last = 0;
        for (int c = 0; c < 40 && hs < 4; c++) begin
            @(negedge clk);
            if (cpu_b.req_ready || dbg_b.req_ready) begin
                if (hs > 0) check("t3_spacing", cyc - last, WAIT_B + 2);
                last = cyc;
                hs++;
            end
        end
        check("t3_handshakes", hs, 4);
        step();
        cpu_b.req_valid = 0; dbg_b.req_valid = 0;
        repeat (WAIT_B + 3) step();

        // CPU raised during a DBG access must wait, then be granted
        dbg_b.req_valid = 1; dbg_b.req_write = 0; dbg_b.req_addr = 32'h28;
        exp_grant_b.push_back(1'b1);
        exp_resp_b.push_back('{id: 1'b1, rdata: 32'hC0C0000A});
        exp_grant_b.push_back(1'b0);
        exp_resp_b.push_back('{id: 1'b0, rdata: 32'hD0D0000B});
        @(negedge clk);
        check("t4_dbg_ready", dbg_b.req_ready, 1);
        step();
        dbg_b.req_valid = 0;
        cpu_b.req_valid = 1; cpu_b.req_write = 0; cpu_b.req_addr = 32'h2C;
        for (int k = 1; k <= WAIT_B + 1; k++) begin
            @(negedge clk);
            check("t4_cpu_held", cpu_b.req_ready, 0);
        end
        @(negedge clk);
        check("t4_cpu_granted", cpu_b.req_ready, 1);
        step();
        cpu_b.req_valid = 0;
        repeat (WAIT_B + 3) step();

        // Reset in the middle of a CPU store access
        cpu_b.req_valid = 1; cpu_b.req_write = 1; cpu_b.req_addr = 32'h30; cpu_b.req_wdata = 32'h55AA55AA;
        exp_grant_b.push_back(1'b0);
        @(negedge clk);
        check("t5_ready_T", cpu_b.req_ready, 1);
        step();
        cpu_b.req_valid = 0; cpu_b.req_write = 0;
        @(negedge clk);
        check("t5_we_before_rst", we_b, 0);
        #2 reset = 1'b0;
        #1;
        check("t5_async_ready", {cpu_b.req_ready, dbg_b.req_ready}, 0);
        check("t5_async_resp", {cpu_b.resp_valid, dbg_b.resp_valid}, 0);
        check("t5_async_rdata", {cpu_b.resp_rdata, dbg_b.resp_rdata}, 0);
        check("t5_async_mem_bus", {mem_addr_b, mem_din_b}, 0);
        check("t5_async_we", we_b, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_we_in_rst", we_b, 0);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("t5_mem_word12", mem_b[12], 32'h11111111);
        step();
        cpu_b.req_valid = 1; cpu_b.req_write = 0; cpu_b.req_addr = 32'h20;
        dbg_b.req_valid = 1; dbg_b.req_write = 0; dbg_b.req_addr = 32'h24;
        exp_grant_b.push_back(1'b0);
        exp_resp_b.push_back('{id: 1'b0, rdata: 32'hA0A00008});
        @(negedge clk);
        check("t5_first_grant", {cpu_b.req_ready, dbg_b.req_ready}, 2'b10);
        step();
        cpu_b.req_valid = 0; dbg_b.req_valid = 0;
        repeat (WAIT_B + 3) step();

        // Idle for 20 cycles
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("t6_idle", {cpu_b.req_ready, dbg_b.req_ready, cpu_b.resp_valid, dbg_b.resp_valid, we_b,
                              cpu_a.req_ready, dbg_a.req_ready, cpu_a.resp_valid, dbg_a.resp_valid, we_a}, 0);
        end

        // Every expected event must have been observed
        check("end_grant_a_left", exp_grant_a.size(), 0);
        check("end_resp_a_left", exp_resp_a.size(), 0);
        check("end_grant_b_left", exp_grant_b.size(), 0);
        check("end_resp_b_left", exp_resp_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Shares the single-port data memory between two requesters: the CPU load/store port (requester 0) and a debug/loader port (requester 1), e.g. for test-program preload or memory dump.
- Sits between both requesters and the memory block, and drives its address, data_in and write_enable.
- Serialises accesses through a small FSM with a programmable access time, round-robin grant, and a valid/ready request handshake with a one-cycle response pulse.

Parameters:
- ADDR_W, 32, byte-address width. Passed to memory unchanged; memory does word selection.
- DATA_W, 32, data width.
- WAIT_CYCLES, 1, cycles spent in ACCESS per transaction. Legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset. Asserted when 0.
- cpu_req_valid  in  1  CPU request present.
- cpu_req_ready  out  1  CPU request accepted this cycle.
- cpu_req_write  in  1  1=store, 0=load.
- cpu_req_addr  in  ADDR_W  byte address.
- cpu_req_wdata  in  DATA_W  store data.
- cpu_resp_valid  out  1  one-cycle completion pulse.
- cpu_resp_rdata  out  DATA_W  load data; 0 for stores.
- dbg_req_valid / dbg_req_ready / dbg_req_write / dbg_req_addr / dbg_req_wdata / dbg_resp_valid / dbg_resp_rdata: same as the cpu_* ports, for requester 1.
- mem_address  out  ADDR_W  to memory address.
- mem_data_in  out  DATA_W  to memory data_in.
- mem_write_enable  out  1  to memory write_enable.
- mem_data_out  in  DATA_W  combinational read data from memory.

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (reset==0, asynchronous):
  - state=IDLE, wait counter=0, priority pointer=CPU, latched request cleared.
  - All outputs 0: both req_ready, both resp_valid, both rdata, mem_address, mem_data_in, mem_write_enable.
- IDLE, no valid: stay in IDLE; all ready=0.
- IDLE, any valid:
  - Grant combinationally in the same cycle: exactly one req_ready=1, for the winner.
  - A single requester always wins.
  - If both are valid, the requester named by the priority pointer wins.
  - On the clock edge: latch the winner's id, write, addr and wdata; counter=WAIT_CYCLES-1; go to ACCESS.
  - Request inputs are don't-care after the handshake.
- ACCESS:
  - mem_address and mem_data_in come from the latched request.
  - Counter decrements each cycle.
  - In the cycle where the counter is 0 (the last ACCESS cycle):
    - Write: mem_write_enable=1 for exactly this one cycle.
    - Read: mem_data_out is captured into the rdata register.
  - Then go to RESP.
  - mem_write_enable=0 in every other cycle and state.
- RESP:
  - The granted requester's resp_valid=1 for exactly one cycle, with rdata valid (0 for a write).
  - Priority pointer flips to the non-granted requester.
  - Next state is IDLE.
  - There is no response backpressure; requesters must accept the pulse.
- Latency: handshake at cycle T; ACCESS covers T+1..T+WAIT_CYCLES; resp_valid at T+WAIT_CYCLES+1.
  - The earliest next handshake is T+WAIT_CYCLES+2, so throughput is one transaction per WAIT_CYCLES+2 cycles.
- req_ready is 0 in ACCESS and RESP. Requests raised then are held pending and are not dropped; the requester keeps valid high.
- In IDLE with no active transaction, mem_address and mem_data_in hold their last values. Only mem_write_enable is semantically significant.
- rdata registers hold their value between responses. They are only meaningful while resp_valid=1.
- Reset mid-transaction aborts: no write is issued, no resp_valid is generated, and the FSM returns to IDLE.
- A starved requester waits at most one transaction when the other requester is continuously valid (round-robin guarantee).

Decomposition:
- Shared package memory_arbiter_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_ACCESS, ARB_RESP}.
  - Requester id constants REQ_CPU=1'b0, REQ_DBG=1'b1.
- Sub-module rr_picker_2: combinational 2-way round-robin.
  - Inputs: valid[1:0], priority pointer.
  - Outputs: grant one-hot, grant_id.
  - Verified standalone.

Test Plan:
- Single CPU load, WAIT_CYCLES=1, memory word at byte address 0x8 = 0xDEADBEEF:
  - cpu_req_ready=1 at T.
  - mem_address=0x8 at T+1.
  - cpu_resp_valid=1 with rdata=0xDEADBEEF at T+2.
  - dbg_resp_valid stays 0.
- Debug store, addr 0x10, wdata 0x12345678, WAIT_CYCLES=3:
  - mem_write_enable=1 only at T+3.
  - Memory word 4 = 0x12345678 after T+3.
  - dbg_resp_valid at T+4 with rdata=0.
- Both valid continuously from reset:
  - Grants alternate CPU, DBG, CPU, DBG.
  - Exactly one ready per handshake.
  - Handshakes spaced WAIT_CYCLES+2 apart.
- CPU valid raised during a DBG ACCESS:
  - cpu_req_ready stays 0 until the IDLE cycle after the DBG response.
  - The CPU is then granted, and the request is not lost.
- reset driven low in the middle of an ACCESS for a store:
  - mem_write_enable is never asserted and the target memory word is unchanged.
  - All outputs are 0 immediately, asynchronously.
  - After reset release, the first simultaneous request is granted to the CPU.
- Idle, no valid, for 20 cycles: all ready, resp_valid and mem_write_enable remain 0.
